// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: requester and converter handshake bundle for the shared BCD converter arbiter
interface bcd_conv_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int BCD_W   = 12,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [BCD_W-1:0]          bcd_out;
  logic                      bcd_valid;
  logic                      err;
  logic [ID_W-1:0]           cur_id;
  logic                      busy;
  logic                      conv_start;
  logic [DATA_W-1:0]         conv_data;
  logic                      conv_done;
  logic [BCD_W-1:0]          conv_bcd;
  modport master (
    input  req, req_data, conv_done, conv_bcd,
    output ack, bcd_out, bcd_valid, err, cur_id, busy, conv_start, conv_data
  );
  modport slave (
    output req, req_data, conv_done, conv_bcd,
    input  ack, bcd_out, bcd_valid, err, cur_id, busy, conv_start, conv_data
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one serial binary-to-BCD converter with a response watchdog
module bcd_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int BCD_W   = 12,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 2
) (
  input logic sys_clk,
  input logic sys_rst,
  bcd_conv_arbiter_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [ID_W-1:0]     r_last, w_last;
  logic [ID_W-1:0]     r_id, w_id;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [BCD_W-1:0]    r_bcd, w_bcd;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                r_valid, w_valid;
  logic                r_err, w_err;
  logic                r_start, w_start;
  logic                r_busy;
  logic                w_found;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_win_data;
  // round-robin pick: first request above the last served index, else the lowest one at or below it
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (!w_found && bus.req[j] && j > int'(r_last)) begin
        w_found    = 1'b1;
        w_win      = ID_W'(j);
        w_win_data = bus.req_data[j*DATA_W +: DATA_W];
      end
    for (int j = 0; j < NUM_REQ; j++)
      if (!w_found && bus.req[j]) begin
        w_found    = 1'b1;
        w_win      = ID_W'(j);
        w_win_data = bus.req_data[j*DATA_W +: DATA_W];
      end
  end
  // next-state and next registered outputs; pulses default low so they last exactly one cycle
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_id    = r_id;
    w_data  = r_data;
    w_bcd   = r_bcd;
    w_ack   = '0;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_start = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_state = START;
        w_id    = w_win;
        w_data  = w_win_data;
        w_start = 1'b1;
      end
      START: begin
        w_state = WAIT;
        w_cnt   = '0;
      end
      WAIT: if (bus.conv_done || r_cnt == CNT_W'(TIMEOUT-1)) begin
        w_state = DONE;
        w_bcd   = bus.conv_done ? bus.conv_bcd : '0;
        w_err   = !bus.conv_done;
        w_valid = 1'b1;
        w_ack   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_id;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
      DONE: begin
        w_state = IDLE;
        w_last  = r_id;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and output registers; reset leaves requester 0 with top priority
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= ID_W'(NUM_REQ-1);
      r_id    <= '0;
      r_data  <= '0;
      r_bcd   <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_id    <= w_id;
      r_data  <= w_data;
      r_bcd   <= w_bcd;
      r_ack   <= w_ack;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_start <= w_start;
      r_busy  <= w_state != IDLE;
    end
  assign bus.ack        = r_ack;
  assign bus.bcd_out    = r_bcd;
  assign bus.bcd_valid  = r_valid;
  assign bus.err        = r_err;
  assign bus.cur_id     = r_id;
  assign bus.busy       = r_busy;
  assign bus.conv_start = r_start;
  assign bus.conv_data  = r_data;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed tests with a transaction-age reference model checked every cycle
module tb_bcd_conv_arbiter;
  localparam int N = 4, DW = 8, BW = 12, TO = 64, IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcd_conv_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .BCD_W(BW), .ID_W(IW)) bus();
  bcd_conv_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BCD_W(BW), .TIMEOUT(TO), .ID_W(IW)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus.master)
  );
  int total = 0, bad = 0, cyc = 0, conv_lat = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [BW-1:0] to_bcd(input logic [DW-1:0] x);
    int v;
    v = int'(x);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  // converter stand-in: answers conv_lat cycles after the start pulse, never when conv_lat is 0
  initial forever begin
    @(posedge clk);
    if (!rst && bus.conv_start && conv_lat > 0) begin
      repeat (conv_lat - 1) @(posedge clk);
      @(negedge clk);
      bus.conv_bcd  = to_bcd(bus.conv_data);
      bus.conv_done = 1'b1;
      @(negedge clk);
      bus.conv_done = 1'b0;
    end
  end
  // reference model: one transaction at a time, tracked by its age since the grant
  logic [N-1:0]  e_ack;
  logic          e_valid, e_err, e_busy, e_start;
  logic [BW-1:0] e_bcd;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_id;
  int            m_last, m_age, mk;
  bit            m_act, m_ackd;
  always @(posedge clk or posedge rst)
    if (rst) begin
      e_ack = '0; e_valid = 0; e_err = 0; e_busy = 0; e_start = 0;
      e_bcd = '0; e_data = '0; e_id = '0;
      m_last = N - 1; m_act = 0; m_ackd = 0; m_age = 0;
    end else begin
      e_start = 0; e_ack = '0; e_valid = 0; e_err = 0;
      if (m_ackd) begin
        m_ackd = 0; m_act = 0; m_last = int'(e_id);
      end else if (m_act) begin
        if (m_age >= 1 && (bus.conv_done || m_age == TO)) begin
          m_ackd  = 1;
          e_ack   = N'(1) << e_id;
          e_valid = 1;
          e_err   = !bus.conv_done;
          e_bcd   = bus.conv_done ? bus.conv_bcd : '0;
        end else m_age++;
      end else if (bus.req != '0) begin
        for (int o = 1; o <= N; o++) begin
          mk = (m_last + o) % N;
          if (!m_act && bus.req[mk]) begin
            m_act = 1; m_age = 0; e_id = IW'(mk);
            e_data = bus.req_data[mk*DW +: DW];
          end
        end
        e_start = m_act;
      end
      e_busy = m_act;
    end
  // every-cycle comparison against the model
  always @(negedge clk)
    if (!rst) begin
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("bcd_valid", 32'(bus.bcd_valid), 32'(e_valid));
      chk("err", 32'(bus.err), 32'(e_err));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("conv_start", 32'(bus.conv_start), 32'(e_start));
      chk("conv_data", 32'(bus.conv_data), 32'(e_data));
      chk("cur_id", 32'(bus.cur_id), 32'(e_id));
      if (e_valid) chk("bcd_out", 32'(bus.bcd_out), 32'(e_bcd));
    end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.conv_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 300 && at < 0; i++) begin
      @(negedge clk);
      if (bus.conv_start) at = cyc;
    end
    if (at < 0) chk("start_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_ack(output int at, output int id, output logic [BW-1:0] b, output logic e);
    at = -1; id = -1; b = '0; e = 1'b0;
    for (int i = 0; i < 300 && at < 0; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        at = cyc; b = bus.bcd_out; e = bus.err;
        for (int j = 0; j < N; j++) if (bus.ack[j]) id = j;
      end
    end
    if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask
  int s, a, id;
  logic [BW-1:0] b;
  logic e;
  int rr_id [5] = '{0, 1, 2, 3, 0};
  logic [BW-1:0] rr_bcd [5] = '{12'h000, 12'h009, 12'h100, 12'h199, 12'h000};
  initial begin
    bus.req = '0; bus.req_data = '0; bus.conv_done = 1'b0; bus.conv_bcd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cur_id", 32'(bus.cur_id), 32'd0);
    chk("rst_conv_data", 32'(bus.conv_data), 32'd0);
    chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
    rst = 1'b0;
    // single request with a 20-cycle converter
    conv_lat = 20;
    @(negedge clk);
    bus.req_data[15:8] = 8'd255;
    bus.req = 4'b0010;
    wait_start(s);
    chk("single_conv_data", 32'(bus.conv_data), 32'd255);
    @(negedge clk);
    chk("single_start_pulse", 32'(bus.conv_start), 32'd0);
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("single_latency", 32'(a - s), 32'd21);
    chk("single_id", 32'(id), 32'd1);
    chk("single_bcd", 32'(b), 32'h255);
    chk("single_err", 32'(e), 32'd0);
    @(negedge clk);
    chk("single_busy_low", 32'(bus.busy), 32'd0);
    // round-robin across all four
    do_reset();
    conv_lat = 3;
    bus.req_data = {8'd199, 8'd100, 8'd9, 8'd0};
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(a, id, b, e);
      chk("rr_id", 32'(id), 32'(rr_id[i]));
      chk("rr_bcd", 32'(b), 32'(rr_bcd[i]));
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
    // fairness: requester 2 arrives while 0 is served and holds the floor next
    do_reset();
    conv_lat = 10;
    bus.req_data = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.req = 4'b0001;
    wait_start(s);
    bus.req[2] = 1'b1;
    wait_ack(a, id, b, e);
    chk("fair_first", 32'(id), 32'd0);
    wait_ack(a, id, b, e);
    chk("fair_second", 32'(id), 32'd2);
    chk("fair_second_bcd", 32'(b), 32'h003);
    wait_ack(a, id, b, e);
    chk("fair_third", 32'(id), 32'd0);
    bus.req = '0;
    repeat (3) @(negedge clk);
    // watchdog: silent converter, then an answer on the final wait cycle
    do_reset();
    conv_lat = 0;
    bus.req_data = {8'd0, 8'd42, 8'd0, 8'd0};
    bus.req = 4'b0100;
    wait_start(s);
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("to_latency", 32'(a - s), 32'd65);
    chk("to_err", 32'(e), 32'd1);
    chk("to_bcd", 32'(b), 32'd0);
    chk("to_id", 32'(id), 32'd2);
    repeat (2) @(negedge clk);
    conv_lat = 64;
    bus.req = 4'b0100;
    wait_start(s);
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("edge_latency", 32'(a - s), 32'd65);
    chk("edge_err", 32'(e), 32'd0);
    chk("edge_bcd", 32'(b), 32'h042);
    repeat (2) @(negedge clk);
    // done pulses in IDLE and START are ignored
    do_reset();
    conv_lat = 0;
    bus.req_data = {8'd0, 8'd0, 8'd0, 8'd7};
    bus.conv_bcd = 12'h777;
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.conv_done = 1'b0;
    @(negedge clk);
    chk("stale_idle_busy", 32'(bus.busy), 32'd0);
    chk("stale_idle_ack", 32'(bus.ack), 32'd0);
    bus.req = 4'b0001;
    bus.conv_done = 1'b1;
    @(negedge clk);
    chk("stale_start", 32'(bus.conv_start), 32'd1);
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stale_no_ack", 32'(bus.ack), 32'd0);
    end
    bus.conv_bcd = 12'h007;
    bus.conv_done = 1'b1;
    fork begin @(negedge clk); bus.conv_done = 1'b0; end join_none
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("stale_bcd", 32'(b), 32'h007);
    chk("stale_err", 32'(e), 32'd0);
    repeat (3) @(negedge clk);
    // asynchronous reset in the middle of WAIT
    do_reset();
    conv_lat = 0;
    bus.req = 4'b0010;
    wait_start(s);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_cur_id", 32'(bus.cur_id), 32'd0);
    chk("arst_conv_data", 32'(bus.conv_data), 32'd0);
    chk("arst_outs", 32'({bus.ack, bus.bcd_valid, bus.err, bus.conv_start}), 32'd0);
    chk("arst_bcd", 32'(bus.bcd_out), 32'd0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    conv_lat = 2;
    bus.req_data = {8'd33, 8'd22, 8'd11, 8'd5};
    bus.req = 4'b1000;
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("arst_only_req3", 32'(id), 32'd3);
    chk("arst_req3_bcd", 32'(b), 32'h033);
    repeat (3) @(negedge clk);
    do_reset();
    bus.req = 4'b1111;
    wait_ack(a, id, b, e);
    bus.req = '0;
    chk("arst_prio0", 32'(id), 32'd0);
    chk("arst_prio0_bcd", 32'(b), 32'h005);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
